calc_seq: RTL and testbench
===========================

# calc_seq

Operation sequencer for the button calculator. It debounces the raw pushbuttons and latches the operation-select buttons into stable op-select lines for the ALU encoder. It lets the ALU settle, then issues a single-cycle accumulator write-enable, so one press of the down button causes exactly one accumulate. It sits between the board buttons and the calculator datapath: its outputs replace the direct btnc/btnl/btnr/btnd connections to the encoder and accumulator.

## Interface
- DEBOUNCE_CYCLES, 4: consecutive stable synchronized cycles required before a debounced button changes; ≥1. Set ~1,000,000 for 100 MHz hardware.
- SETTLE_CYCLES, 2: cycles op_* are held before acc_we; ≥1.
- clk  in  1  system clock, all logic on rising edge
- btnu  in  1  reset: asynchronous, active-high
- btnc_raw, btnl_raw, btnr_raw, btnd_raw  in  1 each  raw asynchronous buttons
- alu_zero  in  1  ALU zero flag, valid while op_* are stable
- op_c, op_l, op_r  out  1 each  registered op-select bits to the ALU encoder
- acc_we  out  1  one-cycle accumulator write-enable
- busy  out  1  high whenever the FSM is not in IDLE
- zero_flag  out  1  alu_zero sampled on the last commit
- op_count  out  8  number of commits; wraps 255→0

## Operation
- Reset (btnu high, asynchronous) clears the following immediately:
  - all synchronizer flops and debounce counters and states;
  - the btnd edge register;
  - op_c/op_l/op_r, zero_flag and op_count;
  - FSM, to IDLE.
- With the FSM in IDLE, acc_we=0 and busy=0.
- Per button: 2-FF synchronizer giving s, debounced state db, counter cnt of width clog2(DEBOUNCE_CYCLES)+1.
  - On each edge where s≠db: if cnt==DEBOUNCE_CYCLES-1 then db<=s and cnt<=0; otherwise cnt++.
  - On each edge where s==db: cnt<=0.
- Press event: rise = db_d & ~db_d_q, where db_d_q is db_d registered.
- FSM (Moore):
  - IDLE: rise → LATCH.
  - LATCH: op_c/op_l/op_r <= debounced btnc/btnl/btnr; settle counter cleared → SETTLE.
  - SETTLE: counter increments each cycle; when counter==SETTLE_CYCLES-1 → COMMIT.
  - COMMIT: acc_we=1; zero_flag<=alu_zero; op_count<=op_count+1 (mod 256) → HOLD.
  - HOLD: wait until db_d==0 → IDLE. This prevents auto-repeat on a held button.
- Outputs are decoded from state:
  - acc_we=1 only in COMMIT;
  - busy=1 in LATCH, SETTLE, COMMIT and HOLD.
- op_* change only in LATCH. They hold their value in every other state, including across IDLE, so the ALU result stays stable for display.
- Button changes on btnc/btnl/btnr after LATCH have no effect until the next press.
- Releasing btnd during SETTLE does not abort: COMMIT still occurs once, and HOLD exits on the next cycle.
- A btnd glitch shorter than DEBOUNCE_CYCLES synchronized cycles never produces rise.
- Asserting btnu in any state aborts: no acc_we, counts lost, all outputs reset.

## Timing
- Raw input sampled high at edge k → s high after edge k+1 → db high after edge k+1+DEBOUNCE_CYCLES.
- btnd path, with D = DEBOUNCE_CYCLES:
  - rise is visible in the cycle after edge k+1+D;
  - state = LATCH after edge k+2+D;
  - op_* updated after edge k+3+D.
- acc_we is high for exactly 1 cycle, starting SETTLE_CYCLES cycles after op_* update.
- op_count and zero_flag update at the edge that ends COMMIT, i.e. the same edge at which the accumulator captures.
- Minimum spacing between commits: release debounce (D cycles) plus press debounce.
- Release path: HOLD → IDLE at the edge after db_d falls.
- All outputs are glitch-free registered values or single-state decodes.

## Test plan
Parameters: DEBOUNCE_CYCLES=4, SETTLE_CYCLES=2.
- Reset: assert btnu mid-cycle, in any state → all outputs 0 immediately, without waiting for a clock edge; after release, busy=0 and op_count=0.
- Single press, btnl_raw=1 and btnr_raw=0 held, btnd_raw high for 20 cycles:
  - op_l=1 and op_c=op_r=0 exactly 7 cycles after the first sampled btnd edge;
  - acc_we pulses once, 2 cycles later;
  - op_count=1.
- Bounce: btnd_raw toggled with high intervals of 3 cycles for 30 cycles, then low → no acc_we, op_count stays 0, busy stays 0.
- Held button: btnd_raw high for 200 cycles → exactly one acc_we; busy returns to 0 within 6 cycles after release.
- Op change and zero flag:
  - press with btnc_raw=1 while alu_zero=1 at COMMIT → zero_flag=1;
  - change btnc_raw during SETTLE → op_c unchanged;
  - next press with alu_zero=0 → zero_flag=0.
- Wrap and abort:
  - 256 clean presses → op_count=0 and 256 acc_we pulses;
  - press followed by btnu during SETTLE → no acc_we, op_count=0.

Source files
------------

// File: rtl/calc_seq.sv
// Button calculator operation sequencer: debounces raw buttons, latches op-select bits,
// waits for the ALU to settle, then issues one accumulator write per debounced btnd press.
module calc_seq #(
   parameter int DEBOUNCE_CYCLES = 4,
   parameter int SETTLE_CYCLES   = 2
) (
   input  logic       clk,
   input  logic       btnu,
   input  logic       btnc_raw,
   input  logic       btnl_raw,
   input  logic       btnr_raw,
   input  logic       btnd_raw,
   input  logic       alu_zero,
   output logic       op_c,
   output logic       op_l,
   output logic       op_r,
   output logic       acc_we,
   output logic       busy,
   output logic       zero_flag,
   output logic [7:0] op_count
);

   localparam int CW = $clog2(DEBOUNCE_CYCLES) + 1;
   localparam int SW = $clog2(SETTLE_CYCLES) + 1;
   localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);
   localparam logic [SW-1:0] SET_LAST = SW'(SETTLE_CYCLES - 1);

   typedef enum logic [2:0] {IDLE, LATCH, SETTLE, COMMIT, HOLD} state_t;

   // Button index: 0=btnc, 1=btnl, 2=btnr, 3=btnd
   logic [3:0]         raw;
   logic [3:0]         meta_q, s_q, db_q, db_d;
   logic [3:0][CW-1:0] cnt_q, cnt_d;
   logic               btnd_dly_q;
   logic               rise;

   state_t             state_q, state_d;
   logic [SW-1:0]      settle_q, settle_d;
   logic [2:0]         op_q, op_d;
   logic               zf_q, zf_d;
   logic [7:0]         count_q, count_d;

   assign raw  = {btnd_raw, btnr_raw, btnl_raw, btnc_raw};
   assign rise = db_q[3] & ~btnd_dly_q;

   always_comb begin
      db_d  = db_q;
      cnt_d = cnt_q;
      for (int i = 0; i < 4; i++) begin
         if (s_q[i] != db_q[i]) begin
            if (cnt_q[i] == CNT_LAST) begin
               db_d[i]  = s_q[i];
               cnt_d[i] = '0;
            end else begin
               cnt_d[i] = cnt_q[i] + CW'(1);
            end
         end else begin
            cnt_d[i] = '0;
         end
      end
   end

   always_ff @(posedge clk or posedge btnu) begin
      if (btnu) begin
         meta_q     <= '0;
         s_q        <= '0;
         db_q       <= '0;
         cnt_q      <= '0;
         btnd_dly_q <= 1'b0;
      end else begin
         meta_q     <= raw;
         s_q        <= meta_q;
         db_q       <= db_d;
         cnt_q      <= cnt_d;
         btnd_dly_q <= db_q[3];
      end
   end

   always_comb begin
      state_d  = state_q;
      settle_d = settle_q;
      op_d     = op_q;
      zf_d     = zf_q;
      count_d  = count_q;
      acc_we   = 1'b0;
      busy     = 1'b1;
      case (state_q)
         IDLE: begin
            busy = 1'b0;
            if (rise) state_d = LATCH;
         end
         LATCH: begin
            op_d     = db_q[2:0];
            settle_d = '0;
            state_d  = SETTLE;
         end
         SETTLE: begin
            if (settle_q == SET_LAST) state_d = COMMIT;
            else                      settle_d = settle_q + SW'(1);
         end
         COMMIT: begin
            acc_we  = 1'b1;
            zf_d    = alu_zero;
            count_d = count_q + 8'd1;
            state_d = HOLD;
         end
         HOLD: begin
            // Wait for release so a held button never auto-repeats
            if (!db_q[3]) state_d = IDLE;
         end
         default: begin
            busy    = 1'b0;
            state_d = IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or posedge btnu) begin
      if (btnu) begin
         state_q  <= IDLE;
         settle_q <= '0;
         op_q     <= '0;
         zf_q     <= 1'b0;
         count_q  <= '0;
      end else begin
         state_q  <= state_d;
         settle_q <= settle_d;
         op_q     <= op_d;
         zf_q     <= zf_d;
         count_q  <= count_d;
      end
   end

   assign op_c      = op_q[0];
   assign op_l      = op_q[1];
   assign op_r      = op_q[2];
   assign zero_flag = zf_q;
   assign op_count  = count_q;

endmodule

// File: tb/tb_calc_seq.sv
// Directed bench for calc_seq: stimulus pushes expected commits into a queue,
// a monitor pops and compares each time acc_we is seen.
module tb_calc_seq;

   logic       clk = 1'b0;
   logic       btnu, btnc_raw, btnl_raw, btnr_raw, btnd_raw, alu_zero;
   logic       op_c, op_l, op_r, acc_we, busy, zero_flag;
   logic [7:0] op_count;

   typedef struct {
      logic [2:0] op;   // {r,l,c}
      logic       zf;
      logic [7:0] cnt;
   } exp_t;

   exp_t exp_q[$];
   int   checks = 0;
   int   errors = 0;
   int   we_cnt = 0;

   calc_seq #(.DEBOUNCE_CYCLES(4), .SETTLE_CYCLES(2)) dut (
      .clk(clk), .btnu(btnu),
      .btnc_raw(btnc_raw), .btnl_raw(btnl_raw), .btnr_raw(btnr_raw), .btnd_raw(btnd_raw),
      .alu_zero(alu_zero),
      .op_c(op_c), .op_l(op_l), .op_r(op_r),
      .acc_we(acc_we), .busy(busy), .zero_flag(zero_flag), .op_count(op_count)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic press(input int high_cycles);
      btnd_raw = 1'b1;
      repeat (high_cycles) @(negedge clk);
      btnd_raw = 1'b0;
   endtask

   // Monitor: every acc_we pulse must match the oldest expected commit
   initial begin
      exp_t e;
      forever begin
         @(negedge clk);
         if (acc_we === 1'b1) begin
            we_cnt++;
            if (exp_q.size() == 0) begin
               checks++;
               errors++;
               $display("FAIL unexpected_acc_we: got pulse expected none at %0t", $time);
            end else begin
               e = exp_q.pop_front();
               check("commit_op", {29'd0, op_r, op_l, op_c}, {29'd0, e.op});
               @(negedge clk);
               check("commit_zero_flag", {31'd0, zero_flag}, {31'd0, e.zf});
               check("commit_op_count", {24'd0, op_count}, {24'd0, e.cnt});
               check("acc_we_single_cycle", {31'd0, acc_we}, 32'd0);
            end
         end
      end
   end

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation did not finish, expected completion");
      $fatal(1, "watchdog");
   end

   initial begin
      int   base;
      int   n;
      logic busy_seen;

      btnu = 1'b1; btnc_raw = 1'b0; btnl_raw = 1'b0; btnr_raw = 1'b0;
      btnd_raw = 1'b0; alu_zero = 1'b0;
      #2;
      check("reset_outputs", {24'd0, op_c, op_l, op_r, acc_we, busy, zero_flag, 2'b00},
            32'd0);
      check("reset_op_count", {24'd0, op_count}, 32'd0);
      @(negedge clk) btnu = 1'b0;
      repeat (3) @(negedge clk);
      check("post_reset_busy", {31'd0, busy}, 32'd0);
      check("post_reset_op_count", {24'd0, op_count}, 32'd0);

      // Single press with btnl held: op update 7 edges after first sampled btnd edge
      btnl_raw = 1'b1;
      repeat (10) @(negedge clk);
      exp_q.push_back('{3'b010, 1'b0, 8'd1});
      btnd_raw = 1'b1;
      repeat (7) @(posedge clk);
      @(negedge clk);
      check("op_l_before_latch", {31'd0, op_l}, 32'd0);
      check("busy_in_latch", {31'd0, busy}, 32'd1);
      @(negedge clk);
      check("op_after_latch", {29'd0, op_r, op_l, op_c}, 32'b010);
      @(negedge clk);
      check("acc_we_settle", {31'd0, acc_we}, 32'd0);
      @(negedge clk);
      check("acc_we_commit", {31'd0, acc_we}, 32'd1);
      repeat (10) @(negedge clk);
      btnd_raw = 1'b0;
      repeat (15) @(negedge clk);
      check("single_we_count", we_cnt, 32'd1);
      check("single_busy_idle", {31'd0, busy}, 32'd0);

      // Bounce: 3-cycle high glitches never debounce
      busy_seen = 1'b0;
      for (int i = 0; i < 5; i++) begin
         btnd_raw = 1'b1;
         repeat (3) begin @(negedge clk); busy_seen |= busy; end
         btnd_raw = 1'b0;
         repeat (3) begin @(negedge clk); busy_seen |= busy; end
      end
      repeat (15) begin @(negedge clk); busy_seen |= busy; end
      check("bounce_busy", {31'd0, busy_seen}, 32'd0);
      check("bounce_op_count", {24'd0, op_count}, 32'd1);
      check("bounce_we_count", we_cnt, 32'd1);

      // Held button: one commit, busy drops 6 edges after release is sampled
      exp_q.push_back('{3'b010, 1'b0, 8'd2});
      press(200);
      @(posedge clk);
      n = 0;
      forever begin
         @(negedge clk);
         if (!busy || n >= 20) break;
         @(posedge clk);
         n++;
      end
      check("release_busy_cycles", n, 32'd6);
      check("held_we_count", we_cnt, 32'd2);

      // Op change during SETTLE is ignored; zero flag follows alu_zero at COMMIT
      btnl_raw = 1'b0; btnc_raw = 1'b1; alu_zero = 1'b1;
      repeat (10) @(negedge clk);
      exp_q.push_back('{3'b001, 1'b1, 8'd3});
      btnd_raw = 1'b1;
      repeat (8) @(posedge clk);
      @(negedge clk);
      btnc_raw = 1'b0;
      repeat (11) @(negedge clk);
      btnd_raw = 1'b0;
      repeat (15) @(negedge clk);
      alu_zero = 1'b0;
      exp_q.push_back('{3'b000, 1'b0, 8'd4});
      press(20);
      repeat (15) @(negedge clk);
      check("opchange_we_count", we_cnt, 32'd4);

      // Wrap: reset, then 256 clean presses bring op_count back to 0
      btnu = 1'b1;
      #1;
      check("midrun_reset_count", {24'd0, op_count}, 32'd0);
      @(negedge clk) btnu = 1'b0;
      btnr_raw = 1'b1; alu_zero = 1'b1;
      repeat (10) @(negedge clk);
      base = we_cnt;
      for (int i = 0; i < 256; i++) begin
         exp_q.push_back('{3'b100, 1'b1, 8'(i + 1)});
         press(12);
         repeat (8) @(negedge clk);
      end
      repeat (5) @(negedge clk);
      check("wrap_op_count", {24'd0, op_count}, 32'd0);
      check("wrap_we_count", we_cnt - base, 32'd256);

      // Abort: btnu during SETTLE clears everything at once, no commit
      base = we_cnt;
      btnd_raw = 1'b1;
      repeat (8) @(posedge clk);
      @(negedge clk);
      check("abort_pre_busy", {31'd0, busy}, 32'd1);
      check("abort_pre_zero_flag", {31'd0, zero_flag}, 32'd1);
      #2 btnu = 1'b1;
      #1;
      check("abort_outputs", {24'd0, op_c, op_l, op_r, acc_we, busy, zero_flag, 2'b00},
            32'd0);
      @(negedge clk) btnd_raw = 1'b0;
      repeat (3) @(negedge clk);
      btnu = 1'b0;
      repeat (20) @(negedge clk);
      check("abort_we_count", we_cnt - base, 32'd0);
      check("abort_op_count", {24'd0, op_count}, 32'd0);
      check("abort_busy", {31'd0, busy}, 32'd0);

      check("scoreboard_drained", exp_q.size(), 32'd0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
